// File: rtl/mp_cache_tag_array_gen2.sv
// Dual-port tag array with masked writes, optional cross-port forwarding and
// a self-clearing init sweep entered from reset or flush.
module mp_cache_tag_array_gen2 #(
  parameter int unsigned DATA_WIDTH = 26,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned FWD        = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  output logic                  busy,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] wmask0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  rvalid0,
  input  logic                  csb1,
  input  logic                  web1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] wmask1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  rvalid1
);

  localparam int unsigned RAM_DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [0:0]  S_INIT    = 1'b0;
  localparam logic [0:0]  S_IDLE    = 1'b1;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic [0:0]            state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  busy_nxt, rvalid0_nxt, rvalid1_nxt;
  logic [DATA_WIDTH-1:0] dout0_nxt, dout1_nxt;

  logic                  idle, wr0, rd0, wr1, rd1, same_addr;
  logic [DATA_WIDTH-1:0] w0, w1, base0;

  // Port decode; accesses only exist while the sweep is not running
  assign idle      = (state == S_IDLE);
  assign wr0       = idle && !csb0 && !web0;
  assign rd0       = idle && !csb0 &&  web0;
  assign wr1       = idle && !csb1 && !web1;
  assign rd1       = idle && !csb1 &&  web1;
  assign same_addr = (addr0 == addr1);

  // Port 1 merges first so that port 0 wins on overlapping mask bits
  assign w1    = (mem[addr1] & ~wmask1) | (din1 & wmask1);
  assign base0 = (wr1 && same_addr) ? w1 : mem[addr0];
  assign w0    = (base0 & ~wmask0) | (din0 & wmask0);

  // Next-state and registered-output logic
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    busy_nxt    = 1'b1;
    rvalid0_nxt = 1'b0;
    rvalid1_nxt = 1'b0;
    dout0_nxt   = dout0;
    dout1_nxt   = dout1;

    case (state)
      S_INIT: begin
        cnt_nxt = cnt + ADDR_WIDTH'(1);
        if (&cnt) state_nxt = S_IDLE;
      end
      default: begin
        if (flush) begin
          state_nxt = S_INIT;
          cnt_nxt   = '0;
        end
      end
    endcase

    busy_nxt = (state_nxt == S_INIT);

    if (rd0) begin
      rvalid0_nxt = 1'b1;
      dout0_nxt   = ((FWD != 0) && wr1 && same_addr) ? w1 : mem[addr0];
    end
    // When port 1 reads, port 1 is not writing, so w0 is old word merged with din0
    if (rd1) begin
      rvalid1_nxt = 1'b1;
      dout1_nxt   = ((FWD != 0) && wr0 && same_addr) ? w0 : mem[addr1];
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_INIT;
      cnt     <= '0;
      busy    <= 1'b1;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      dout0   <= '0;
      dout1   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      busy    <= busy_nxt;
      rvalid0 <= rvalid0_nxt;
      rvalid1 <= rvalid1_nxt;
      dout0   <= dout0_nxt;
      dout1   <= dout1_nxt;
    end
  end

  // Storage has no reset; the sweep owns it while in INIT
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[cnt] <= INIT_VAL;
    end else begin
      if (wr1) mem[addr1] <= w1;
      if (wr0) mem[addr0] <= w0;
    end
  end

endmodule

// File: tb/tb_mp_cache_tag_array_gen2.sv
// Bench for mp_cache_tag_array_gen2: vector table plus scoreboard on the default
// instance, and a wide/deep FWD=0 instance for sweep length and no-forward reads.
module tb_mp_cache_tag_array_gen2;

  localparam int unsigned DW  = 26;
  localparam int unsigned AW  = 4;
  localparam int unsigned DWB = 40;
  localparam int unsigned AWB = 6;
  localparam logic [DW-1:0]  ONES   = '1;
  localparam logic [DW-1:0]  Z      = '0;
  localparam logic [DW-1:0]  PAT    = 26'h2AAAAAA;
  localparam logic [DWB-1:0] INIT_B = 40'hA5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush, busy;
  logic          csb0, web0, rvalid0, csb1, web1, rvalid1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0, wmask0, dout0, din1, wmask1, dout1;

  logic           rst_n_b, flush_b, busy_b;
  logic           csb0_b, web0_b, rvalid0_b, csb1_b, web1_b, rvalid1_b;
  logic [AWB-1:0] addr0_b, addr1_b;
  logic [DWB-1:0] din0_b, wmask0_b, dout0_b, din1_b, wmask1_b, dout1_b;

  mp_cache_tag_array_gen2 u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .wmask0(wmask0),
    .dout0(dout0), .rvalid0(rvalid0),
    .csb1(csb1), .web1(web1), .addr1(addr1), .din1(din1), .wmask1(wmask1),
    .dout1(dout1), .rvalid1(rvalid1)
  );

  mp_cache_tag_array_gen2 #(
    .DATA_WIDTH(DWB), .ADDR_WIDTH(AWB), .FWD(0), .INIT_VAL(INIT_B)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .flush(flush_b), .busy(busy_b),
    .csb0(csb0_b), .web0(web0_b), .addr0(addr0_b), .din0(din0_b), .wmask0(wmask0_b),
    .dout0(dout0_b), .rvalid0(rvalid0_b),
    .csb1(csb1_b), .web1(web1_b), .addr1(addr1_b), .din1(din1_b), .wmask1(wmask1_b),
    .dout1(dout1_b), .rvalid1(rvalid1_b)
  );

  typedef struct {
    logic          c0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0, m0, e0;
    logic          c1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1, m1, e1;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] last0, last1;
  logic          mon_en = 1'b0;
  vec_t          tbl[14];
  vec_t          idle_v;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic c0, input logic w0, input logic [AW-1:0] a0,
                              input logic [DW-1:0] d0, input logic [DW-1:0] m0,
                              input logic [DW-1:0] e0,
                              input logic c1, input logic w1, input logic [AW-1:0] a1,
                              input logic [DW-1:0] d1, input logic [DW-1:0] m1,
                              input logic [DW-1:0] e1);
    vec_t v;
    v.c0 = c0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.m0 = m0; v.e0 = e0;
    v.c1 = c1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.m1 = m1; v.e1 = e1;
    return v;
  endfunction

  // Scoreboard: every read pushed at drive time must pop exactly one edge later
  always @(posedge clk) begin
    logic [DW-1:0] e;
    logic          ev;
    #1;
    if (mon_en && rst_n) begin
      ev = (q0.size() != 0);
      check("rvalid0", 64'(rvalid0), 64'(ev));
      if (ev) begin
        e = q0.pop_front();
        check("dout0", 64'(dout0), 64'(e));
        last0 = e;
      end else begin
        check("dout0_hold", 64'(dout0), 64'(last0));
      end
      ev = (q1.size() != 0);
      check("rvalid1", 64'(rvalid1), 64'(ev));
      if (ev) begin
        e = q1.pop_front();
        check("dout1", 64'(dout1), 64'(e));
        last1 = e;
      end else begin
        check("dout1_hold", 64'(dout1), 64'(last1));
      end
    end
  end

  task automatic set_idle();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; web1 = 1'b1; flush = 1'b0;
  endtask

  task automatic apply(input vec_t v, input logic fl);
    @(negedge clk);
    csb0 = v.c0; web0 = v.w0; addr0 = v.a0; din0 = v.d0; wmask0 = v.m0;
    csb1 = v.c1; web1 = v.w1; addr1 = v.a1; din1 = v.d1; wmask1 = v.m1;
    flush = fl;
    if (!v.c0 && v.w0) q0.push_back(v.e0);
    if (!v.c1 && v.w1) q1.push_back(v.e1);
  endtask

  // Random accesses and flushes while busy; all must be ignored
  task automatic junk();
    @(negedge clk);
    csb0 = 1'($urandom_range(0, 1)); web0 = 1'($urandom_range(0, 1));
    addr0 = AW'($urandom); din0 = DW'($urandom); wmask0 = DW'($urandom);
    csb1 = 1'($urandom_range(0, 1)); web1 = 1'($urandom_range(0, 1));
    addr1 = AW'($urandom); din1 = DW'($urandom); wmask1 = DW'($urandom);
    flush = 1'($urandom_range(0, 1));
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 200) begin
      junk();
      @(posedge clk);
      #1;
      n++;
    end
    set_idle();
  endtask

  task automatic reset_a();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    set_idle();
    #1;
    check("rst_busy", 64'(busy), 64'(1));
    check("rst_dout0", 64'(dout0), 64'(0));
    check("rst_dout1", 64'(dout1), 64'(0));
    check("rst_rvalid0", 64'(rvalid0), 64'(0));
    check("rst_rvalid1", 64'(rvalid1), 64'(0));
    last0 = '0;
    last1 = '0;
    mon_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic read_all(input logic [DW-1:0] exp);
    for (int i = 0; i < 16; i++)
      apply(mk(1'b0, 1'b1, AW'(i), Z, Z, exp, 1'b0, 1'b1, AW'(15 - i), Z, Z, exp), 1'b0);
    apply(idle_v, 1'b0);
  endtask

  task automatic fill(input logic [DW-1:0] val);
    for (int i = 0; i < 8; i++)
      apply(mk(1'b0, 1'b0, AW'(2 * i), val, ONES, Z, 1'b0, 1'b0, AW'(2 * i + 1), val, ONES, Z), 1'b0);
  endtask

  initial begin
    int n;
    rst_n = 1'b1; rst_n_b = 1'b1;
    set_idle();
    addr0 = '0; addr1 = '0; din0 = '0; din1 = '0; wmask0 = '0; wmask1 = '0;
    flush_b = 1'b0; csb0_b = 1'b1; web0_b = 1'b1; csb1_b = 1'b1; web1_b = 1'b1;
    addr0_b = '0; addr1_b = '0; din0_b = '0; din1_b = '0; wmask0_b = '0; wmask1_b = '0;
    last0 = '0; last1 = '0;
    idle_v = mk(1'b1, 1'b1, 4'd0, Z, Z, Z, 1'b1, 1'b1, 4'd0, Z, Z, Z);

    tbl[0]  = mk(1'b0, 1'b0, 4'd3, ONES, 26'hFF, Z,          1'b1, 1'b1, 4'd0, Z, Z, Z);
    tbl[1]  = mk(1'b1, 1'b1, 4'd0, Z, Z, Z,                  1'b0, 1'b1, 4'd3, Z, Z, 26'hFF);
    tbl[2]  = mk(1'b0, 1'b0, 4'd5, 26'h1234567, ONES, Z,     1'b0, 1'b1, 4'd5, Z, Z, 26'h1234567);
    tbl[3]  = mk(1'b0, 1'b1, 4'd3, Z, Z, 26'hFF,             1'b0, 1'b1, 4'd5, Z, Z, 26'h1234567);
    tbl[4]  = mk(1'b0, 1'b0, 4'd7, 26'h1, 26'h1, Z,          1'b0, 1'b0, 4'd7, ONES, 26'hFF, Z);
    tbl[5]  = mk(1'b0, 1'b1, 4'd7, Z, Z, 26'hFF,             1'b0, 1'b1, 4'd7, Z, Z, 26'hFF);
    tbl[6]  = mk(1'b0, 1'b1, 4'd9, Z, Z, PAT,                1'b0, 1'b0, 4'd9, PAT, ONES, Z);
    tbl[7]  = mk(1'b0, 1'b0, 4'd9, Z, Z, Z,                  1'b1, 1'b1, 4'd0, Z, Z, Z);
    tbl[8]  = mk(1'b0, 1'b1, 4'd9, Z, Z, PAT,                1'b1, 1'b1, 4'd0, Z, Z, Z);
    tbl[9]  = mk(1'b0, 1'b1, 4'd9, Z, Z, 26'hAAA,            1'b0, 1'b0, 4'd9, Z, 26'h3FFF000, Z);
    tbl[10] = mk(1'b1, 1'b1, 4'd0, Z, Z, Z,                  1'b0, 1'b1, 4'd9, Z, Z, 26'hAAA);
    tbl[11] = mk(1'b0, 1'b0, 4'd10, 26'hF0F, 26'hFFF, Z,     1'b0, 1'b0, 4'd10, ONES, 26'hFF0F0, Z);
    tbl[12] = mk(1'b0, 1'b1, 4'd10, Z, Z, 26'hFFF0F,         1'b0, 1'b1, 4'd10, Z, Z, 26'hFFF0F);
    tbl[13] = mk(1'b0, 1'b1, 4'd15, Z, Z, Z,                 1'b0, 1'b1, 4'd0, Z, Z, Z);

    #1 rst_n_b = 1'b0;

    // Power-up sweep, then everything reads back as INIT_VAL
    reset_a();
    count_busy(n);
    check("busy_cycles_reset", 64'(n), 64'(16));
    read_all(Z);

    foreach (tbl[i]) apply(tbl[i], 1'b0);
    apply(idle_v, 1'b0);

    // Flush with a read in the same cycle; junk during the sweep is ignored
    fill(PAT);
    apply(mk(1'b0, 1'b1, 4'd4, Z, Z, PAT, 1'b0, 1'b1, 4'd6, Z, Z, PAT), 1'b1);
    @(posedge clk);
    #1;
    count_busy(n);
    check("busy_cycles_flush", 64'(n), 64'(16));
    read_all(Z);

    // Reset landing at sweep count 8 restarts a full sweep
    fill(PAT);
    apply(mk(1'b0, 1'b1, 4'd1, Z, Z, PAT, 1'b0, 1'b1, 4'd14, Z, Z, PAT), 1'b0);
    apply(idle_v, 1'b1);
    @(posedge clk);
    set_idle();
    repeat (7) @(posedge clk);
    reset_a();
    count_busy(n);
    check("busy_cycles_midreset", 64'(n), 64'(16));
    read_all(Z);

    // Wide/deep instance without forwarding
    check("b_rst_busy", 64'(busy_b), 64'(1));
    check("b_rst_dout0", 64'(dout0_b), 64'(0));
    @(posedge clk);
    #2;
    rst_n_b = 1'b1;
    n = 0;
    while (busy_b && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b_busy_cycles", 64'(n), 64'(64));
    @(negedge clk);
    csb0_b = 1'b0; web0_b = 1'b0; addr0_b = 6'd5; din0_b = '1; wmask0_b = '1;
    csb1_b = 1'b0; web1_b = 1'b1; addr1_b = 6'd5;
    @(posedge clk);
    #1;
    check("b_rvalid0_on_write", 64'(rvalid0_b), 64'(0));
    check("b_rvalid1_nofwd", 64'(rvalid1_b), 64'(1));
    check("b_dout1_nofwd", 64'(dout1_b), 64'(INIT_B));
    @(negedge clk);
    web0_b = 1'b1; addr0_b = 6'd63;
    @(posedge clk);
    #1;
    check("b_dout1_written", 64'(dout1_b), 64'({DWB{1'b1}}));
    check("b_dout0_top_addr", 64'(dout0_b), 64'(INIT_B));
    @(negedge clk);
    csb0_b = 1'b1; csb1_b = 1'b1;
    @(posedge clk);
    #1;
    check("b_rvalid1_idle", 64'(rvalid1_b), 64'(0));
    check("b_dout1_hold", 64'(dout1_b), 64'({DWB{1'b1}}));

    check("q0_drained", 64'(q0.size()), 64'(0));
    check("q1_drained", 64'(q1.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
